// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared grant/state encodings and request record for ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

  localparam int unsigned c_addr_w = 32;
  localparam int unsigned c_data_w = 16;
  localparam int unsigned c_mask_w = 2;
  localparam int unsigned c_pend_w = 4;

  // State value doubles as the grant status code
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPI     = 2'd1,
    ST_HOST    = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

  typedef struct packed {
    logic [c_addr_w-1:0] addr;
    logic                write_enable;
    logic [c_mask_w-1:0] write_mask;
    logic [c_data_w-1:0] write_data;
  } ram_req_t;

endpackage
`default_nettype wire

// File: rtl/ram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : ram_refresh_timer
// Brief    : Refresh interval counter plus saturating owed-refresh counter.
// Revision : 1.0 - initial release
// ============================================================================
module ram_refresh_timer
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL    = 780,
  parameter int unsigned REFRESH_MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                refresh_done,
  output logic [c_pend_w-1:0] refresh_pending
);

  localparam int unsigned        c_cnt_w = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(REFRESH_INTERVAL - 1);
  localparam logic [c_pend_w-1:0] c_max  = c_pend_w'(REFRESH_MAX_PENDING);

  logic [c_cnt_w-1:0]  r_count;
  logic [c_pend_w-1:0] r_pending;
  logic                w_wrap;

  assign w_wrap          = (r_count == c_last);
  assign refresh_pending = r_pending;

  // A wrap and a completed refresh in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
      if (w_wrap && !refresh_done) begin
        if (r_pending < c_max) r_pending <= r_pending + 1'b1;
      end else if (refresh_done && !w_wrap) begin
        if (r_pending != '0) r_pending <= r_pending - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Arbitrates SPI, host and refresh access to a single RAM port.
//            Refresh scheduling is built only with RAM_ARBITER_REFRESH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL    = 780,
  parameter int unsigned REFRESH_MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_critical,
  input  logic                spi_refresh_inhibit,
  input  logic [c_addr_w-1:0] spi_addr,
  input  logic                spi_enable,
  input  logic                spi_write_enable,
  input  logic [c_mask_w-1:0] spi_write_mask,
  input  logic [c_data_w-1:0] spi_write_data,
  output logic [c_data_w-1:0] spi_read_data,
  output logic                spi_data_valid,
  input  logic [c_addr_w-1:0] host_addr,
  input  logic                host_enable,
  input  logic                host_write_enable,
  input  logic [c_mask_w-1:0] host_write_mask,
  input  logic [c_data_w-1:0] host_write_data,
  output logic [c_data_w-1:0] host_read_data,
  output logic                host_data_valid,
  output logic [c_addr_w-1:0] ram_addr,
  output logic                ram_enable,
  output logic                ram_write_enable,
  output logic [c_mask_w-1:0] ram_write_mask,
  output logic [c_data_w-1:0] ram_write_data,
  input  logic [c_data_w-1:0] ram_read_data,
  input  logic                ram_data_valid,
  output logic                ram_refresh,
  input  logic                ram_refresh_done,
  output logic [1:0]          grant,
  output logic [c_pend_w-1:0] refresh_pending
);

  state_t              r_state;
  ram_req_t            r_req;
  logic                r_ram_enable;
  logic                r_ram_refresh;
  ram_req_t            w_spi_req;
  ram_req_t            w_host_req;
  logic [c_pend_w-1:0] w_pending;
  logic                w_refresh_ok;

`ifdef RAM_ARBITER_REFRESH_EN
  logic w_refresh_ack;

  assign w_refresh_ack = (r_state == ST_REFRESH) && ram_refresh_done;

  ram_refresh_timer #(
    .REFRESH_INTERVAL    (REFRESH_INTERVAL),
    .REFRESH_MAX_PENDING (REFRESH_MAX_PENDING)
  ) u_refresh_timer (
    .clk             (clk),
    .reset           (reset),
    .refresh_done    (w_refresh_ack),
    .refresh_pending (w_pending)
  );
`else
  // With nothing ever owed, the REFRESH state is unreachable
  assign w_pending = '0;
`endif

  assign w_spi_req    = '{spi_addr, spi_write_enable, spi_write_mask, spi_write_data};
  assign w_host_req   = '{host_addr, host_write_enable, host_write_mask, host_write_data};
  assign w_refresh_ok = (w_pending != '0) && !spi_refresh_inhibit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      r_ram_enable  <= 1'b0;
      r_ram_refresh <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (spi_enable) begin
            r_state      <= ST_SPI;
            r_req        <= w_spi_req;
            r_ram_enable <= 1'b1;
          end else if (w_refresh_ok) begin
            r_state       <= ST_REFRESH;
            r_ram_refresh <= 1'b1;
          end else if (host_enable && !spi_critical) begin
            r_state      <= ST_HOST;
            r_req        <= w_host_req;
            r_ram_enable <= 1'b1;
          end
        end
        // Requests are latched at grant, so a dropped enable cannot abort
        ST_SPI, ST_HOST: begin
          if (ram_data_valid) begin
            r_state            <= ST_IDLE;
            r_ram_enable       <= 1'b0;
            r_req.write_enable <= 1'b0;
          end
        end
        ST_REFRESH: begin
          if (ram_refresh_done) begin
            r_state       <= ST_IDLE;
            r_ram_refresh <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr         = r_req.addr;
  assign ram_write_enable = r_req.write_enable;
  assign ram_write_mask   = r_req.write_mask;
  assign ram_write_data   = r_req.write_data;
  assign ram_enable       = r_ram_enable;
  assign ram_refresh      = r_ram_refresh;
  assign grant            = r_state;
  assign refresh_pending  = w_pending;

  assign spi_data_valid  = (r_state == ST_SPI)  && ram_data_valid;
  assign host_data_valid = (r_state == ST_HOST) && ram_data_valid;
  assign spi_read_data   = ram_read_data;
  assign host_read_data  = ram_read_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed cycle-table bench for ram_arbiter plus corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_critical = 0, spi_refresh_inhibit = 1;
  logic [31:0] spi_addr = '0;
  logic        spi_enable = 0, spi_write_enable = 0;
  logic [1:0]  spi_write_mask = '0;
  logic [15:0] spi_write_data = '0;
  logic [15:0] spi_read_data;
  logic        spi_data_valid;
  logic [31:0] host_addr = '0;
  logic        host_enable = 0, host_write_enable = 0;
  logic [1:0]  host_write_mask = '0;
  logic [15:0] host_write_data = '0;
  logic [15:0] host_read_data;
  logic        host_data_valid;
  logic [31:0] ram_addr;
  logic        ram_enable, ram_write_enable;
  logic [1:0]  ram_write_mask;
  logic [15:0] ram_write_data;
  logic [15:0] ram_read_data = '0;
  logic        ram_data_valid = 0;
  logic        ram_refresh;
  logic        ram_refresh_done = 0;
  logic [1:0]  grant;
  logic [3:0]  refresh_pending;

  always #5 clk = ~clk;

  ram_arbiter #(.REFRESH_INTERVAL(16), .REFRESH_MAX_PENDING(8)) dut (
    .clk(clk), .reset(reset),
    .spi_critical(spi_critical), .spi_refresh_inhibit(spi_refresh_inhibit),
    .spi_addr(spi_addr), .spi_enable(spi_enable), .spi_write_enable(spi_write_enable),
    .spi_write_mask(spi_write_mask), .spi_write_data(spi_write_data),
    .spi_read_data(spi_read_data), .spi_data_valid(spi_data_valid),
    .host_addr(host_addr), .host_enable(host_enable), .host_write_enable(host_write_enable),
    .host_write_mask(host_write_mask), .host_write_data(host_write_data),
    .host_read_data(host_read_data), .host_data_valid(host_data_valid),
    .ram_addr(ram_addr), .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
    .ram_write_mask(ram_write_mask), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .ram_data_valid(ram_data_valid),
    .ram_refresh(ram_refresh), .ram_refresh_done(ram_refresh_done),
    .grant(grant), .refresh_pending(refresh_pending)
  );

  // One row = inputs held for a cycle and outputs expected during that cycle
  typedef struct {
    logic        rst, se, swe;
    logic [31:0] saddr;
    logic        he, hwe;
    logic [31:0] haddr;
    logic        crit, dv;
    logic [1:0]  eg;
    logic        een, ewe, achk;
    logic [31:0] eaddr;
    logic        esdv, ehdv;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic rst, se, swe, input logic [31:0] saddr,
                     input logic he, hwe, input logic [31:0] haddr,
                     input logic crit, dv, input logic [1:0] eg,
                     input logic een, ewe, achk, input logic [31:0] eaddr,
                     input logic esdv, ehdv);
    vec_t v;
    v.rst = rst; v.se = se; v.swe = swe; v.saddr = saddr;
    v.he = he; v.hwe = hwe; v.haddr = haddr; v.crit = crit; v.dv = dv;
    v.eg = eg; v.een = een; v.ewe = ewe; v.achk = achk; v.eaddr = eaddr;
    v.esdv = esdv; v.ehdv = ehdv;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int bad, found, lat, issued, gbad;
    logic [15:0] rd;

    // rst se swe saddr | he hwe haddr | crit dv | grant en we achk addr | sdv hdv
    add(0,0,0,0,      0,0,0,      0,0, 0,0,0,1,0,      0,0);
    add(0,1,0,'h123,  0,0,0,      0,0, 0,0,0,1,0,      0,0);
    add(0,1,0,'h123,  0,0,0,      0,0, 1,1,0,1,'h123,  0,0);
    add(0,1,0,'h123,  0,0,0,      0,1, 1,1,0,1,'h123,  1,0);
    add(0,0,0,0,      0,0,0,      0,0, 0,0,0,0,0,      0,0);
    add(0,1,1,'h10,   1,1,'h20,   0,0, 0,0,0,0,0,      0,0);
    add(0,1,1,'h10,   1,1,'h20,   0,0, 1,1,1,1,'h10,   0,0);
    add(0,1,1,'h10,   1,1,'h20,   0,1, 1,1,1,1,'h10,   1,0);
    add(0,0,0,0,      1,1,'h20,   0,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,1,'h20,   0,0, 2,1,1,1,'h20,   0,0);
    add(0,0,0,0,      0,0,0,      0,0, 2,1,1,1,'h20,   0,0);
    add(0,0,0,0,      0,0,0,      0,1, 2,1,1,1,'h20,   0,1);
    add(0,0,0,0,      0,0,0,      0,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,0,'h30,   1,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,0,'h30,   1,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,0,'h30,   0,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,0,'h30,   0,0, 2,1,0,1,'h30,   0,0);
    add(0,0,0,0,      1,0,'h30,   1,0, 2,1,0,1,'h30,   0,0);
    add(0,0,0,0,      1,0,'h30,   1,1, 2,1,0,1,'h30,   0,1);
    add(0,0,0,0,      0,0,0,      1,0, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      0,0,0,      0,1, 0,0,0,0,0,      0,0);
    add(0,0,0,0,      1,0,'h40,   0,0, 0,0,0,0,0,      0,0);
    add(1,0,0,0,      1,0,'h40,   0,0, 2,1,0,1,'h40,   0,0);
    add(0,0,0,0,      0,0,0,      0,1, 0,0,0,1,0,      0,0);
    add(0,0,0,0,      0,0,0,      0,0, 0,0,0,1,0,      0,0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_pending", refresh_pending, 0);
    check("reset_refresh", ram_refresh, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; spi_enable = vecs[i].se; spi_write_enable = vecs[i].swe;
      spi_addr = vecs[i].saddr; host_enable = vecs[i].he; host_write_enable = vecs[i].hwe;
      host_addr = vecs[i].haddr; spi_critical = vecs[i].crit; ram_data_valid = vecs[i].dv;
      rd = 16'hA500 + 16'(i);
      ram_read_data = rd;
      #1;
      check($sformatf("row%0d_grant", i), grant, vecs[i].eg);
      check($sformatf("row%0d_ram_enable", i), ram_enable, vecs[i].een);
      check($sformatf("row%0d_ram_we", i), ram_write_enable, vecs[i].ewe);
      if (vecs[i].achk) check($sformatf("row%0d_ram_addr", i), ram_addr, vecs[i].eaddr);
      check($sformatf("row%0d_spi_dv", i), spi_data_valid, vecs[i].esdv);
      check($sformatf("row%0d_host_dv", i), host_data_valid, vecs[i].ehdv);
      check($sformatf("row%0d_spi_rd", i), spi_read_data, rd);
      check($sformatf("row%0d_host_rd", i), host_read_data, rd);
    end
    @(negedge clk);
    reset = 0; spi_enable = 0; spi_write_enable = 0; host_enable = 0;
    host_write_enable = 0; spi_critical = 0; ram_data_valid = 0;

    // SPI masked write: request fields copied to the RAM port
    @(negedge clk);
    spi_enable = 1; spi_write_enable = 1; spi_write_mask = 2'b01;
    spi_write_data = 16'hBEEF; spi_addr = 32'h77;
    @(negedge clk); #1;
    check("wr_grant", grant, 1);
    check("wr_we", ram_write_enable, 1);
    check("wr_mask", ram_write_mask, 2'b01);
    check("wr_data", ram_write_data, 16'hBEEF);
    check("wr_addr", ram_addr, 32'h77);
    ram_data_valid = 1; #1;
    check("wr_spi_dv", spi_data_valid, 1);
    @(negedge clk);
    spi_enable = 0; spi_write_enable = 0; ram_data_valid = 0; #1;
    check("wr_en_drop", ram_enable, 0);
    check("wr_we_drop", ram_write_enable, 0);

    // Long spi_critical lockout of a waiting host
    @(negedge clk);
    spi_critical = 1; host_enable = 1; host_addr = 32'h55;
    bad = 0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (grant == 2'd2) bad++;
    end
    check("crit_no_host_grant", bad, 0);
    spi_critical = 0;
    found = 0; lat = 0;
    for (int n = 1; n <= 3 && found == 0; n++) begin
      @(negedge clk); #1;
      if (grant == 2'd2 && ram_enable) begin found = 1; lat = n; end
    end
    check("crit_release_grant", found, 1);
    check("crit_release_latency_le2", (lat <= 2) ? 1 : 0, 1);
    check("crit_release_addr", ram_addr, 32'h55);
    ram_data_valid = 1; #1;
    check("crit_host_dv", host_data_valid, 1);
    check("crit_spi_dv", spi_data_valid, 0);
    @(negedge clk);
    host_enable = 0; ram_data_valid = 0;

`ifdef RAM_ARBITER_REFRESH_EN
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; spi_refresh_inhibit = 1;
    repeat (200) @(negedge clk);
    #1;
    check("ref_saturate", refresh_pending, 8);
    check("ref_inhibit_grant", grant, 0);
    spi_refresh_inhibit = 0;
    issued = 0; gbad = 0;
    for (int k = 0; k < 8; k++) begin
      found = 0;
      for (int n = 0; n < 3 && found == 0; n++) begin
        @(negedge clk);
        ram_refresh_done = 0;
        #1;
        if (ram_refresh) found = 1;
      end
      if (found != 0) begin
        issued++;
        if (grant != 2'd3 || ram_enable) gbad++;
        ram_refresh_done = 1;
      end
    end
    @(negedge clk);
    ram_refresh_done = 0;
    check("ref_back_to_back", issued, 8);
    check("ref_grant3", gbad, 0);
`else
    spi_refresh_inhibit = 0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk); #1;
      if (ram_refresh !== 1'b0 || refresh_pending !== 4'd0 || grant == 2'd3) bad++;
    end
    check("norefresh_quiet", bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
